// File: rtl/bp_pkg.sv
// bp_pkg
// Shared definitions for the branch direction predictor:
//   - default parameter constants for the predictor table
//   - weak_nt(): reset value of a counter (weakly not-taken)
//   - sat_inc()/sat_dec(): saturating counter arithmetic on a 32-bit carrier
// No ports; imported by bp_sat_counter and branch_predictor_gshare.
package bp_pkg;

  localparam int DEF_INDEX_W = 4;
  localparam int DEF_CNT_W   = 2;
  localparam int DEF_GHR_W   = 4;

  localparam logic [15:0] MISPRED_MAX = 16'hFFFF;

  // Largest value that still predicts not-taken: 2^(cnt_w-1)-1.
  function automatic int weak_nt(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] value);
    return (value == 32'd0) ? 32'd0 : value - 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter
// One CNT_W-bit saturating up/down counter of the prediction table.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (loads weakly not-taken)
//   en     in   apply one step this cycle
//   up     in   1 = count up (taken), 0 = count down (not taken)
//   taken  out  counter MSB, the predicted direction
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic up,
  output logic taken
);

  localparam logic [31:0]      MAX_VAL   = (32'd1 << CNT_W) - 32'd1;
  localparam logic [CNT_W-1:0] RESET_VAL = CNT_W'(weak_nt(CNT_W));

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_VAL;
    end else if (en) begin
      if (up) begin
        count <= CNT_W'(sat_inc(32'(count), MAX_VAL));
      end else begin
        count <= CNT_W'(sat_dec(32'(count)));
      end
    end
  end

  assign taken = count[CNT_W-1];

endmodule

// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare
// Direction predictor with 2^INDEX_W saturating counters. Build option
// BP_GSHARE_EN hashes the lookup PC with a speculative global history;
// without it the table is indexed by the PC alone (bimodal).
// Ports:
//   CLK                in   clock, rising edge
//   RST                in   asynchronous active-low reset
//   Lookup_en          in   request a prediction this cycle
//   Lookup_PC          in   low PC bits of the fetched branch
//   Prediction         out  registered predicted direction (1 = taken)
//   Pred_valid         out  registered: Prediction/Pred_index are new
//   Pred_index         out  registered table index used by the lookup
//   Update_en          in   a branch resolved this cycle
//   Update_index       in   Pred_index carried back with the branch
//   Update_taken       in   actual outcome
//   Update_mispredict  in   predicted direction was wrong (with Update_en)
//   Mispredict_count   out  saturating count of mispredicts
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int GHR_W   = DEF_GHR_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Lookup_en,
  input  logic [INDEX_W-1:0] Lookup_PC,
  output logic               Prediction,
  output logic               Pred_valid,
  output logic [INDEX_W-1:0] Pred_index,
  input  logic               Update_en,
  input  logic [INDEX_W-1:0] Update_index,
  input  logic               Update_taken,
  input  logic               Update_mispredict,
  output logic [15:0]        Mispredict_count
);

  localparam int DEPTH = 1 << INDEX_W;

  logic [DEPTH-1:0]   counter_taken;
  logic [INDEX_W-1:0] lookup_idx;
  logic               taken_pred;
  logic               mispredict;

  assign mispredict = Update_en && Update_mispredict;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cnt
    bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (CLK),
      .rst_n (RST),
      .en    (Update_en && (Update_index == INDEX_W'(i))),
      .up    (Update_taken),
      .taken (counter_taken[i])
    );
  end

  // The read is combinational and sees the pre-update counter, so a
  // same-cycle update to the same entry is not bypassed.
  assign taken_pred = counter_taken[lookup_idx];

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_spec;
  logic [GHR_W-1:0] ghr_commit;
  logic [GHR_W-1:0] ghr_commit_next;

  // Width cast drops the oldest history bit, which also covers GHR_W = 1.
  assign ghr_commit_next = GHR_W'({ghr_commit, Update_taken});
  assign lookup_idx      = Lookup_PC ^ INDEX_W'(ghr_spec);

  // Mispredict recovery overrides the speculative shift of a same-cycle
  // lookup; the restored history is the freshly committed one.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ghr_spec   <= '0;
      ghr_commit <= '0;
    end else begin
      if (Update_en) begin
        ghr_commit <= ghr_commit_next;
      end
      if (mispredict) begin
        ghr_spec <= ghr_commit_next;
      end else if (Lookup_en) begin
        ghr_spec <= GHR_W'({ghr_spec, taken_pred});
      end
    end
  end
`else
  assign lookup_idx = Lookup_PC;
`endif

  // Output stage: Prediction/Pred_index hold while no lookup is issued.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Prediction <= 1'b0;
      Pred_valid <= 1'b0;
      Pred_index <= '0;
    end else begin
      Pred_valid <= Lookup_en;
      if (Lookup_en) begin
        Prediction <= taken_pred;
        Pred_index <= lookup_idx;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Mispredict_count <= '0;
    end else if (mispredict && (Mispredict_count != MISPRED_MAX)) begin
      Mispredict_count <= Mispredict_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb_branch_predictor_gshare
// Randomised and directed bench for branch_predictor_gshare with a
// behavioural reference model. Follows the BP_GSHARE_EN build option.
module tb_branch_predictor_gshare;

  localparam int INDEX_W = 4;
  localparam int CNT_W   = 2;
  localparam int GHR_W   = 4;
  localparam int DEPTH   = 1 << INDEX_W;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int CHALF   = 1 << (CNT_W - 1);
  localparam int HMOD    = 1 << GHR_W;
`ifdef BP_GSHARE_EN
  localparam bit GSHARE = 1'b1;
`else
  localparam bit GSHARE = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               lookup_en = 1'b0;
  logic [INDEX_W-1:0] lookup_pc = '0;
  logic               prediction;
  logic               pred_valid;
  logic [INDEX_W-1:0] pred_index;
  logic               update_en = 1'b0;
  logic [INDEX_W-1:0] update_index = '0;
  logic               update_taken = 1'b0;
  logic               update_mispredict = 1'b0;
  logic [15:0]        mispredict_count;

  int checks = 0;
  int passes = 0;

  // Reference model state
  int          cnt_m [DEPTH];
  int          ghr_spec_m;
  int          ghr_commit_m;
  int          mis_m;
  logic        exp_pred;
  logic        exp_valid;
  int          exp_index;

  always #5 clk = ~clk;

  branch_predictor_gshare #(
    .INDEX_W(INDEX_W), .CNT_W(CNT_W), .GHR_W(GHR_W)
  ) dut (
    .CLK               (clk),
    .RST               (rst),
    .Lookup_en         (lookup_en),
    .Lookup_PC         (lookup_pc),
    .Prediction        (prediction),
    .Pred_valid        (pred_valid),
    .Pred_index        (pred_index),
    .Update_en         (update_en),
    .Update_index      (update_index),
    .Update_taken      (update_taken),
    .Update_mispredict (update_mispredict),
    .Mispredict_count  (mispredict_count)
  );

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) cnt_m[i] = CHALF - 1;
    ghr_spec_m   = 0;
    ghr_commit_m = 0;
    mis_m        = 0;
    exp_pred     = 1'b0;
    exp_valid    = 1'b0;
    exp_index    = 0;
  endtask

  task automatic idle_inputs();
    lookup_en         = 1'b0;
    lookup_pc         = '0;
    update_en         = 1'b0;
    update_index      = '0;
    update_taken      = 1'b0;
    update_mispredict = 1'b0;
  endtask

  // Advance the model by one cycle from the current inputs, then clock the
  // DUT and return 1 time unit after the edge.
  task automatic step();
    int idx;
    int new_commit;
    idx = GSHARE ? (int'(lookup_pc) ^ ghr_spec_m) : int'(lookup_pc);
    exp_valid = lookup_en;
    if (lookup_en) begin
      exp_pred  = (cnt_m[idx] >= CHALF);
      exp_index = idx;
    end
    new_commit = (ghr_commit_m * 2 + int'(update_taken)) % HMOD;
    if (update_en) begin
      if (update_taken) cnt_m[update_index] = (cnt_m[update_index] < CMAX) ? cnt_m[update_index] + 1 : CMAX;
      else              cnt_m[update_index] = (cnt_m[update_index] > 0) ? cnt_m[update_index] - 1 : 0;
      ghr_commit_m = new_commit;
    end
    if (update_en && update_mispredict) begin
      ghr_spec_m = new_commit;
      if (mis_m < 65535) mis_m++;
    end else if (lookup_en) begin
      ghr_spec_m = (ghr_spec_m * 2 + int'(exp_pred)) % HMOD;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 rst = 1'b0;
    model_reset();
    #2 rst = 1'b1;
  endtask

  task automatic do_update(input int idx, input bit taken, input int n);
    for (int k = 0; k < n; k++) begin
      idle_inputs();
      update_en    = 1'b1;
      update_index = INDEX_W'(idx);
      update_taken = taken;
      step();
    end
    idle_inputs();
  endtask

  task automatic do_lookup(input int pc);
    idle_inputs();
    lookup_en = 1'b1;
    lookup_pc = INDEX_W'(pc);
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #13;
    checks++; if (prediction !== 1'b0) $display("[TB] FAIL reset_pred: got %0b want 0", prediction); else passes++;
    checks++; if (pred_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b want 0", pred_valid); else passes++;
    checks++; if (pred_index !== '0) $display("[TB] FAIL reset_index: got %0d want 0", pred_index); else passes++;
    checks++; if (mispredict_count !== 16'd0) $display("[TB] FAIL reset_mcount: got %0d want 0", mispredict_count); else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    do_lookup(3);
    checks++; if (pred_valid !== exp_valid) $display("[TB] FAIL first_valid: got %0b want %0b", pred_valid, exp_valid); else passes++;
    checks++; if (prediction !== exp_pred) $display("[TB] FAIL first_pred: got %0b want %0b", prediction, exp_pred); else passes++;
    checks++; if (pred_index !== INDEX_W'(exp_index)) $display("[TB] FAIL first_index: got %0d want %0d", pred_index, exp_index); else passes++;
    step();
    checks++; if (pred_valid !== 1'b0) $display("[TB] FAIL valid_drop: got %0b want 0", pred_valid); else passes++;
    checks++; if (pred_index !== INDEX_W'(exp_index)) $display("[TB] FAIL index_hold: got %0d want %0d", pred_index, exp_index); else passes++;
  endtask

  task automatic test_saturation();
    do_reset();
    do_update(5, 1'b1, 2);
    do_lookup(5);
    checks++; if (prediction !== exp_pred) $display("[TB] FAIL train_pred: got %0b want %0b", prediction, exp_pred); else passes++;
    checks++; if (pred_index !== INDEX_W'(exp_index)) $display("[TB] FAIL train_index: got %0d want %0d", pred_index, exp_index); else passes++;
    do_reset();
    do_update(5, 1'b1, 5);
    do_update(5, 1'b0, 1);
    do_lookup(5);
    checks++; if (prediction !== exp_pred) $display("[TB] FAIL sat_high_pred: got %0b want %0b", prediction, exp_pred); else passes++;
    do_reset();
    do_update(7, 1'b0, 4);
    do_update(7, 1'b1, 1);
    do_lookup(7);
    checks++; if (prediction !== exp_pred) $display("[TB] FAIL sat_low_pred: got %0b want %0b", prediction, exp_pred); else passes++;
  endtask

  task automatic test_history();
    do_reset();
    do_update(1, 1'b1, 2);
    idle_inputs();
    lookup_en = 1'b1;
    lookup_pc = INDEX_W'(1);
    step();
    checks++; if (prediction !== exp_pred) $display("[TB] FAIL hist_pred: got %0b want %0b", prediction, exp_pred); else passes++;
    lookup_pc = INDEX_W'(4);
    step();
    checks++; if (pred_index !== INDEX_W'(exp_index)) $display("[TB] FAIL hist_index: got %0d want %0d", pred_index, exp_index); else passes++;
    checks++; if (pred_valid !== 1'b1) $display("[TB] FAIL b2b_valid: got %0b want 1", pred_valid); else passes++;
    idle_inputs();
  endtask

  task automatic test_mispredict();
    do_reset();
    lookup_en         = 1'b1;
    lookup_pc         = '0;
    update_en         = 1'b1;
    update_index      = INDEX_W'(2);
    update_taken      = 1'b1;
    update_mispredict = 1'b1;
    step();
    checks++; if (mispredict_count !== 16'(mis_m)) $display("[TB] FAIL mis_count: got %0d want %0d", mispredict_count, mis_m); else passes++;
    checks++; if (pred_index !== INDEX_W'(exp_index)) $display("[TB] FAIL mis_pre_index: got %0d want %0d", pred_index, exp_index); else passes++;
    do_lookup(0);
    checks++; if (pred_index !== INDEX_W'(exp_index)) $display("[TB] FAIL mis_repair_index: got %0d want %0d", pred_index, exp_index); else passes++;
    idle_inputs();
    update_mispredict = 1'b1;
    update_taken      = 1'b1;
    step();
    idle_inputs();
    checks++; if (mispredict_count !== 16'(mis_m)) $display("[TB] FAIL mis_gated: got %0d want %0d", mispredict_count, mis_m); else passes++;
  endtask

  task automatic test_async_reset();
    do_update(9, 1'b1, 3);
    do_lookup(9);
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++; if (prediction !== 1'b0) $display("[TB] FAIL async_pred: got %0b want 0", prediction); else passes++;
    checks++; if (pred_valid !== 1'b0) $display("[TB] FAIL async_valid: got %0b want 0", pred_valid); else passes++;
    checks++; if (pred_index !== '0) $display("[TB] FAIL async_index: got %0d want 0", pred_index); else passes++;
    checks++; if (mispredict_count !== 16'd0) $display("[TB] FAIL async_mcount: got %0d want 0", mispredict_count); else passes++;
    #2 rst = 1'b1;
    do_lookup(9);
    checks++; if (prediction !== exp_pred) $display("[TB] FAIL async_after_pred: got %0b want %0b", prediction, exp_pred); else passes++;
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      lookup_en         = ($urandom_range(0, 3) != 0);
      lookup_pc         = INDEX_W'($urandom);
      update_en         = $urandom_range(0, 1) == 1;
      update_index      = INDEX_W'($urandom_range(0, 7));
      update_taken      = ($urandom_range(0, 2) != 0);
      update_mispredict = ($urandom_range(0, 3) == 0);
      step();
      checks++;
      if (pred_valid !== exp_valid || prediction !== exp_pred ||
          pred_index !== INDEX_W'(exp_index) || mispredict_count !== 16'(mis_m)) begin
        $display("[TB] FAIL rand_cycle%0d: got v=%0b p=%0b i=%0d m=%0d want v=%0b p=%0b i=%0d m=%0d",
                 c, pred_valid, prediction, pred_index, mispredict_count,
                 exp_valid, exp_pred, exp_index, mis_m);
      end else begin
        passes++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_count_saturation();
    do_reset();
    update_en         = 1'b1;
    update_mispredict = 1'b1;
    for (int c = 0; c < 65540; c++) begin
      update_index = INDEX_W'(c);
      update_taken = c[0];
      step();
    end
    idle_inputs();
    checks++; if (mispredict_count !== 16'(mis_m)) $display("[TB] FAIL mcount_sat: got %0h want %0h", mispredict_count, mis_m); else passes++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_saturation();
    test_history();
    test_mispredict();
    test_async_reset();
    test_random();
    test_count_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor_gshare.md
# branch_predictor_gshare

Parametrised direction predictor for the fetch stage, replacing the fixed 16-entry bimodal history table. It holds 2^INDEX_W saturating counters of CNT_W bits. With the gshare option compiled in, the counters are indexed by the fetch PC hashed with a speculative global history register. It returns a registered prediction one cycle after lookup, accepts resolved-branch updates from execute, and repairs history on a misprediction.

## Interface
Parameters:
- INDEX_W, 4: table index width; depth = 2^INDEX_W.
- CNT_W, 2: saturating counter width, at least 2.
- GHR_W, 4: global history length, 1 ≤ GHR_W ≤ INDEX_W.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- Lookup_en  in  1  fetch requests a prediction this cycle.
- Lookup_PC  in  INDEX_W  low PC bits of the fetched branch.
- Prediction  out  1  1 = predict taken; registered.
- Pred_valid  out  1  Prediction/Pred_index valid; registered.
- Pred_index  out  INDEX_W  table index used; the pipeline carries it to execute.
- Update_en  in  1  a branch resolved this cycle.
- Update_index  in  INDEX_W  Pred_index returned with the branch.
- Update_taken  in  1  actual outcome.
- Update_mispredict  in  1  predicted direction was wrong; qualified by Update_en.
- Mispredict_count  out  16  saturating mispredict counter.

## Operation
- Reset state:
  - Every counter = 2^(CNT_W-1)-1 (weakly not-taken, 01 for CNT_W=2).
  - GHR_spec = 0 and GHR_commit = 0.
  - Prediction = 0, Pred_valid = 0, Pred_index = 0, Mispredict_count = 0.
- Index: idx = Lookup_PC XOR zero-extended GHR_spec. History occupies the low GHR_W bits.
- Lookup (Lookup_en=1):
  - Read counter[idx]; taken_pred = counter MSB.
  - Register Prediction = taken_pred, Pred_index = idx, Pred_valid = 1.
  - GHR_spec <= {GHR_spec[GHR_W-2:0], taken_pred}.
  - If Lookup_en=0, Pred_valid <= 0 and Prediction/Pred_index hold their values.
- Update (Update_en=1):
  - counter[Update_index] increments if Update_taken=1, else decrements.
  - The counter saturates at 0 and at 2^CNT_W-1.
  - GHR_commit <= {GHR_commit[GHR_W-2:0], Update_taken}.
- Mispredict (Update_en=1 and Update_mispredict=1):
  - GHR_spec <= {GHR_commit[GHR_W-2:0], Update_taken}, which is the new committed history.
  - Mispredict_count increments and saturates at 16'hFFFF.
- Simultaneous events:
  - Lookup and update to the same index: the lookup reads the pre-update value (no bypass). The update still lands.
  - Lookup together with a mispredict: recovery has priority for GHR_spec and the lookup's shift is discarded. The prediction output is still produced, using the pre-recovery GHR_spec.
  - Update_mispredict with Update_en=0: ignored.
- RST low at any time clears all state immediately, regardless of CLK.

## Timing
- Lookup to Prediction/Pred_valid: 1 cycle; the result is visible the cycle after Lookup_en.
- An update is visible to a lookup issued the cycle after the update.
- GHR_spec after a lookup: the next-cycle lookup uses the shifted history. Back-to-back lookups are allowed every cycle.
- Mispredict recovery: the lookup in the cycle after the mispredict uses the repaired history.
- Counter read is combinational from the register array; the output register is the only pipeline stage.

## Configuration
- BP_GSHARE_EN defined: hashed index and speculative/committed GHR logic, as described above.
- BP_GSHARE_EN undefined: idx = Lookup_PC (pure bimodal).
  - GHR_spec and GHR_commit are not instantiated; mispredict still increments Mispredict_count.
  - All ports remain present.

## Structure
- Shared package bp_pkg holds:
  - the counter reset-value function weak_nt(CNT_W);
  - the saturating increment/decrement functions;
  - the default-parameter constants.
- One sub-module, bp_sat_counter (CNT_W-bit saturating counter with enable and direction), instantiated 2^INDEX_W times via generate.

## Test plan
Defaults apply unless noted (INDEX_W=4, CNT_W=2, GHR_W=4, BP_GSHARE_EN defined).
- Reset, then lookup PC=3 -> next cycle Prediction=0, Pred_valid=1, Pred_index=3; GHR_spec=0000.
- Two taken updates to index 5, then lookup PC=5 -> counter 01→10→11, Prediction=1, Pred_index=5.
- Three further taken updates to index 5 -> counter stays 11. One not-taken update -> 10; lookup still predicts 1.
- Train index 1 to 11, then lookup PC=1 -> Prediction=1, GHR_spec=0001. Next-cycle lookup PC=4 -> Pred_index=5.
- With GHR_commit=0000, issue Update_en=1, mispredict=1, taken=1 in the same cycle as Lookup_en -> next cycle GHR_spec=0001 (lookup shift dropped) and Mispredict_count=1. Mispredict with Update_en=0 -> no change.
- Drive RST low mid-stream (between edges) -> all outputs 0 immediately; after release, lookup of any PC -> Prediction=0.
- Rebuild without BP_GSHARE_EN: the sequence from the fourth scenario gives Pred_index=4 on the second lookup.
